// File: rtl/na_current_if.sv
// Start/done handshake and operand/result bus for the sodium-current stage.
interface na_current_if;
    logic               start;
    logic signed [15:0] m_in;
    logic signed [15:0] h_in;
    logic signed [15:0] v_in;
    logic               busy;
    logic               done;
    logic signed [15:0] i_na;

    modport master (output start, m_in, h_in, v_in, input busy, done, i_na);
    modport slave  (input start, m_in, h_in, v_in, output busy, done, i_na);
endinterface

// File: rtl/na_current.sv
// Computes I_Na = G_NA*m^3*h*(V-E_NA) with one shared multiplier over five
// sequenced states; result saturated to 16 bits and held until the next run.
module na_current #(
    parameter int G_NA  = 120,
    parameter int E_NA  = 50,
    parameter int SCALE = 1000,
    parameter int W_ACC = 40
) (
    input  logic         clk,
    input  logic         reset_n,
    na_current_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_M1   = 3'd1,
        S_M2   = 3'd2,
        S_MH   = 3'd3,
        S_MG   = 3'd4,
        S_MV   = 3'd5
    } state_t;

    localparam logic signed [15:0]      SCALE16 = 16'(SCALE);
    localparam logic signed [W_ACC-1:0] SCALE_W = W_ACC'(SCALE);
    localparam logic signed [W_ACC-1:0] GNA_W   = W_ACC'(G_NA);
    localparam logic signed [W_ACC-1:0] ENA_W   = W_ACC'(E_NA);
    localparam logic signed [W_ACC-1:0] SAT_HI  = W_ACC'(32767);
    localparam logic signed [W_ACC-1:0] SAT_LO  = -W_ACC'(32768);

    state_t state, state_nxt;

    logic signed [15:0]      m_r, h_r, v_r;
    logic signed [W_ACC-1:0] p_r;
    logic signed [W_ACC-1:0] op_a, op_b, prod, p_nxt;
    logic                    use_div;
    logic signed [15:0]      i_na_r;
    logic                    done_r;

    // Gating variables are probabilities: pin them into [0, SCALE].
    function automatic logic signed [15:0] clamp_gate(input logic signed [15:0] x);
        if (x < 16'sd0)   return '0;
        if (x > SCALE16)  return SCALE16;
        return x;
    endfunction

    function automatic logic signed [15:0] sat16(input logic signed [W_ACC-1:0] x);
        if (x > SAT_HI) return 16'sh7fff;
        if (x < SAT_LO) return 16'sh8000;
        return x[15:0];
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start) state_nxt = S_M1;
            S_M1:    state_nxt = S_M2;
            S_M2:    state_nxt = S_MH;
            S_MH:    state_nxt = S_MG;
            S_MG:    state_nxt = S_MV;
            S_MV:    state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand steering for the single shared multiplier.
    always_comb begin
        op_a    = p_r;
        op_b    = W_ACC'(m_r);
        use_div = 1'b1;
        case (state)
            S_M1: op_a = W_ACC'(m_r);
            S_M2: op_b = W_ACC'(m_r);
            S_MH: op_b = W_ACC'(h_r);
            S_MG: begin
                op_b    = GNA_W;
                use_div = 1'b0;
            end
            S_MV: op_b = W_ACC'(v_r) - ENA_W;
            default: ;
        endcase
        prod  = op_a * op_b;
        p_nxt = use_div ? (prod / SCALE_W) : prod;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_r    <= '0;
            h_r    <= '0;
            v_r    <= '0;
            p_r    <= '0;
            i_na_r <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        m_r <= clamp_gate(bus.m_in);
                        h_r <= clamp_gate(bus.h_in);
                        v_r <= bus.v_in;
                    end
                end
                S_MV: begin
                    p_r    <= p_nxt;
                    i_na_r <= sat16(p_nxt);
                    done_r <= 1'b1;
                end
                default: p_r <= p_nxt;
            endcase
        end
    end

    assign bus.busy = (state != S_IDLE);
    assign bus.done = done_r;
    assign bus.i_na = i_na_r;
endmodule

// File: tb/tb_na_current.sv
// Randomized and directed checks of na_current against a plain-arithmetic model.
module tb_na_current;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    na_current_if bus();

    na_current dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic int model(input int m, input int h, input int v);
        longint mm, hh, p;
        mm = (m < 0) ? 0 : (m > 1000) ? 1000 : m;
        hh = (h < 0) ? 0 : (h > 1000) ? 1000 : h;
        p  = mm * mm / 1000;
        p  = p * mm / 1000;
        p  = p * hh / 1000;
        p  = p * 120;
        p  = p * (longint'(v) - 50) / 1000;
        if (p > 32767)  p = 32767;
        if (p < -32768) p = -32768;
        return int'(p);
    endfunction

    // One operation: start pulsed for one cycle, operands scrambled afterwards.
    // idx n is the negedge after the n-th posedge following the start drive.
    task automatic run_op(input string nm, input int m, input int h, input int v);
        int exp, done_idx, done_cnt;
        logic signed [15:0] exp16;
        exp = model(m, h, v);
        exp16 = 16'(exp);
        done_idx = -1;
        done_cnt = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.m_in = 16'(m);
        bus.h_in = 16'(h);
        bus.v_in = 16'(v);
        for (int idx = 1; idx <= 8; idx++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.m_in = 16'($urandom);
            bus.h_in = 16'($urandom);
            bus.v_in = 16'($urandom);
            if (bus.done) begin
                done_cnt++;
                if (done_idx < 0) done_idx = idx;
            end
            if (idx >= 2 && idx <= 5) begin
                total++;
                if (bus.busy !== 1'b1) begin
                    bad++;
                    $display("FAIL %s busy idx=%0d got=%b want=1", nm, idx, bus.busy);
                end
            end
            if (idx == 6) begin
                total++;
                if (bus.busy !== 1'b0 || bus.i_na !== exp16) begin
                    bad++;
                    $display("FAIL %s result m=%0d h=%0d v=%0d busy=%b got=%0d want=%0d",
                             nm, m, h, v, bus.busy, bus.i_na, exp16);
                end
            end
        end
        total++;
        if (done_idx != 6 || done_cnt != 1) begin
            bad++;
            $display("FAIL %s done timing got idx=%0d cnt=%0d want idx=6 cnt=1", nm, done_idx, done_cnt);
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.m_in = '0;
        bus.h_in = '0;
        bus.v_in = '0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.i_na !== 16'sd0) begin
            bad++;
            $display("FAIL reset busy=%b done=%b i_na=%0d want 0/0/0", bus.busy, bus.done, bus.i_na);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle busy=%b done=%b want 0/0", bus.busy, bus.done);
        end
    endtask

    task automatic test_directed();
        run_op("full_open", 1000, 1000, 0);
        run_op("half_trunc", 500, 500, 0);
        run_op("resting", 53, 596, -65);
        run_op("sat_hi", 1000, 1000, 32767);
        run_op("sat_lo", 1000, 1000, -32768);
        run_op("clamp_m", 1200, 1000, 0);
        run_op("clamp_h", 1000, -5, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++)
            run_op("random", int'($urandom_range(1400, 0)) - 200,
                   int'($urandom_range(1400, 0)) - 200,
                   int'($signed(16'($urandom))));
    endtask

    task automatic test_back_to_back();
        int done_cnt, first, second;
        done_cnt = 0;
        first = -1;
        second = -1;
        @(negedge clk);
        bus.start = 1'b1;
        bus.m_in = 16'sd1000;
        bus.h_in = 16'sd1000;
        bus.v_in = 16'sd0;
        for (int idx = 1; idx <= 14; idx++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (idx == 2) begin
                bus.start = 1'b1;
                bus.m_in = 16'sd500;
                bus.v_in = 16'sd1234;
            end
            if (bus.done) begin
                done_cnt++;
                if (first < 0) first = idx;
                else if (second < 0) second = idx;
            end
            if (idx == 6) begin
                total++;
                if (bus.i_na !== -16'sd6000) begin
                    bad++;
                    $display("FAIL b2b_ignore got=%0d want=-6000", bus.i_na);
                end
                bus.start = 1'b1;
                bus.m_in = 16'sd500;
                bus.h_in = 16'sd500;
                bus.v_in = 16'sd0;
            end
            if (idx == 12) begin
                total++;
                if (bus.i_na !== -16'sd372) begin
                    bad++;
                    $display("FAIL b2b_second got=%0d want=-372", bus.i_na);
                end
            end
        end
        total++;
        if (done_cnt != 2 || first != 6 || second != 12) begin
            bad++;
            $display("FAIL b2b_done cnt=%0d first=%0d second=%0d want 2/6/12", done_cnt, first, second);
        end
    endtask

    task automatic test_reset_midop();
        int done_cnt;
        done_cnt = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.m_in = 16'sd1000;
        bus.h_in = 16'sd1000;
        bus.v_in = 16'sd100;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.i_na !== 16'sd0) begin
            bad++;
            $display("FAIL midop_reset busy=%b done=%b i_na=%0d want 0/0/0", bus.busy, bus.done, bus.i_na);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done) done_cnt++;
        end
        total++;
        if (done_cnt != 0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL midop_no_done cnt=%0d busy=%b want 0/0", done_cnt, bus.busy);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
